// File: rtl/fft_frame_feeder.sv
// Frame builder in front of the FFT: buffers a valid/ready complex sample
// stream and emits fixed-length frames of 32*2^mode samples, each followed by an idle gap.
module fft_frame_feeder #(
  parameter int WIDTH      = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int GAP_CYCLES = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [2:0]       cfg_mode_sel,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_re,
  input  logic [WIDTH-1:0] s_im,
  input  logic             s_last,
  output logic             data_do_en,
  output logic [WIDTH-1:0] data_do_re,
  output logic [WIDTH-1:0] data_do_im,
  output logic [2:0]       mode_do_sel,
  output logic             frame_do_start,
  output logic             frame_do_done,
  output logic             err_do_len,
  output logic             busy_do
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int GW = $clog2(GAP_CYCLES + 1);
  localparam int EW = 2 * WIDTH + 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;

  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;

  logic [1:0]    state;
  logic [9:0]    sample_cnt;
  logic [9:0]    cnt_max;
  logic [GW-1:0] gap_cnt;

  logic          push;
  logic          pop;
  logic [EW-1:0] head;
  logic [2:0]    mode_eff;
  logic [9:0]    cur_idx;
  logic [9:0]    cur_max;
  logic          at_end;

  assign s_ready = (count < CW'(FIFO_DEPTH));

  // In IDLE the popped sample is index 0 of a frame whose length comes from the
  // live mode request; in RUN it is the next index of the latched frame.
  always_comb begin
    push     = s_valid && s_ready;
    pop      = ((state == ST_IDLE) || (state == ST_RUN)) && (count != '0);
    head     = mem[rd_ptr];
    mode_eff = (cfg_mode_sel > 3'd5) ? 3'd5 : cfg_mode_sel;
    if (state == ST_IDLE) begin
      cur_idx = '0;
      cur_max = 10'((32 << mode_eff) - 1);
    end else begin
      cur_idx = sample_cnt + 10'd1;
      cur_max = cnt_max;
    end
    at_end = (cur_idx == cur_max);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: the pointers define which entries are live.
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= {s_last, s_im, s_re};
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= ST_IDLE;
      sample_cnt     <= '0;
      cnt_max        <= 10'd1023;
      gap_cnt        <= '0;
      mode_do_sel    <= 3'd5;
      busy_do        <= 1'b0;
      data_do_en     <= 1'b0;
      data_do_re     <= '0;
      data_do_im     <= '0;
      frame_do_start <= 1'b0;
      frame_do_done  <= 1'b0;
      err_do_len     <= 1'b0;
    end else begin
      data_do_en     <= pop;
      data_do_re     <= pop ? head[WIDTH-1:0] : '0;
      data_do_im     <= pop ? head[2*WIDTH-1:WIDTH] : '0;
      frame_do_start <= pop && (state == ST_IDLE);
      frame_do_done  <= pop && at_end;
      // The counter owns the frame length; a disagreeing s_last is only flagged.
      err_do_len     <= pop && (head[EW-1] != at_end);

      case (state)
        ST_IDLE: begin
          if (pop) begin
            state       <= ST_RUN;
            mode_do_sel <= mode_eff;
            cnt_max     <= cur_max;
            sample_cnt  <= '0;
            busy_do     <= 1'b1;
          end
        end
        ST_RUN: begin
          if (pop) begin
            sample_cnt <= cur_idx;
            if (at_end) begin
              state   <= ST_GAP;
              gap_cnt <= '0;
            end
          end
        end
        ST_GAP: begin
          if (gap_cnt == GW'(GAP_CYCLES - 1)) begin
            state   <= ST_IDLE;
            busy_do <= 1'b0;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        default: begin
          state   <= ST_IDLE;
          busy_do <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fft_frame_feeder.sv
// Self-checking bench for fft_frame_feeder: random sample streams compared
// against a frame-walking reference model built from queues.
module tb_fft_frame_feeder;

  localparam int W     = 16;
  localparam int DEPTH = 4;
  localparam int GAP   = 4;

  typedef struct {
    logic [W-1:0] re;
    logic [W-1:0] im;
    logic         last;
    int           cyc;
  } smp_t;

  typedef struct {
    logic         en;
    logic [W-1:0] re;
    logic [W-1:0] im;
    logic         start;
    logic         done;
    logic         err;
    logic [2:0]   mode;
    logic         busy;
    logic         ready;
    logic [2:0]   cfg;
    int           cyc;
  } rec_t;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic [2:0]   cfg_mode_sel = 3'd0;
  logic         s_valid = 1'b0;
  logic         s_ready;
  logic [W-1:0] s_re = '0;
  logic [W-1:0] s_im = '0;
  logic         s_last = 1'b0;
  logic         data_do_en;
  logic [W-1:0] data_do_re;
  logic [W-1:0] data_do_im;
  logic [2:0]   mode_do_sel;
  logic         frame_do_start;
  logic         frame_do_done;
  logic         err_do_len;
  logic         busy_do;

  int total = 0;
  int bad   = 0;

  smp_t stim_q[$];
  smp_t pushed_q[$];
  rec_t rec_q[$];
  int   cyc = 0;
  logic [2:0] cfg_prev = 3'd0;

  int         m_pos  = 0;
  int         m_len  = 32;
  logic [2:0] m_mode = 3'd0;

  fft_frame_feeder #(.WIDTH(W), .FIFO_DEPTH(DEPTH), .GAP_CYCLES(GAP)) dut (
    .clock(clock), .reset(reset), .cfg_mode_sel(cfg_mode_sel),
    .s_valid(s_valid), .s_ready(s_ready), .s_re(s_re), .s_im(s_im), .s_last(s_last),
    .data_do_en(data_do_en), .data_do_re(data_do_re), .data_do_im(data_do_im),
    .mode_do_sel(mode_do_sel), .frame_do_start(frame_do_start),
    .frame_do_done(frame_do_done), .err_do_len(err_do_len), .busy_do(busy_do)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    cyc      <= cyc + 1;
    cfg_prev <= cfg_mode_sel;
  end

  // One record per cycle, taken on the falling edge.
  always @(negedge clock) begin
    rec_t r;
    r.en = data_do_en;   r.re = data_do_re;     r.im = data_do_im;
    r.start = frame_do_start; r.done = frame_do_done; r.err = err_do_len;
    r.mode = mode_do_sel; r.busy = busy_do;     r.ready = s_ready;
    r.cfg = cfg_prev;     r.cyc = cyc;
    rec_q.push_back(r);
  end

  function automatic logic [2:0] clamp_mode(input logic [2:0] m);
    return (m > 3'd5) ? 3'd5 : m;
  endfunction

  // Reference: the k-th delivered sample is the k-th accepted one; its place in the
  // frame follows from counting, and a frame's mode is the request seen at its start.
  function automatic logic [37:0] model_next(input smp_t s, input logic [2:0] cfg);
    logic st, dn;
    if (m_pos == 0) begin
      m_mode = clamp_mode(cfg);
      m_len  = 32 << m_mode;
    end
    st = (m_pos == 0);
    dn = (m_pos == m_len - 1);
    m_pos = dn ? 0 : m_pos + 1;
    return {st, dn, (s.last != dn), m_mode, s.re, s.im};
  endfunction

  task automatic tick();
    @(negedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    s_valid = 1'b0;
    repeat (2) tick();
    reset = 1'b0;
    pushed_q.delete();
    m_pos = 0;
  endtask

  task automatic make_stim(input int n, input int last_a, input int last_b);
    smp_t s;
    stim_q.delete();
    for (int i = 0; i < n; i++) begin
      s.re   = W'($urandom);
      s.im   = W'($urandom);
      s.last = (i == last_a) || (i == last_b);
      s.cyc  = 0;
      stim_q.push_back(s);
    end
  endtask

  task automatic drive(input bit toggle, input int switch_at, input logic [2:0] cfg_new);
    int   idx = 0;
    int   guard = 0;
    bit   phase = 1'b1;
    smp_t p;
    while (idx < stim_q.size() && guard < 20000) begin
      tick();
      if (idx == switch_at) cfg_mode_sel = cfg_new;
      s_re    = stim_q[idx].re;
      s_im    = stim_q[idx].im;
      s_last  = stim_q[idx].last;
      s_valid = toggle ? phase : 1'b1;
      if (s_valid && s_ready) begin
        p = stim_q[idx];
        p.cyc = cyc + 1;
        pushed_q.push_back(p);
        idx++;
      end
      phase = !phase;
      guard++;
    end
    tick();
    s_valid = 1'b0;
  endtask

  task automatic wait_enabled(input int base, input int n, input int budget,
                              output bit ok, output int got);
    int scan = base;
    ok = 1'b0;
    got = 0;
    for (int c = 0; c < budget && !ok; c++) begin
      tick();
      while (scan < rec_q.size()) begin
        if (rec_q[scan].en) got++;
        scan++;
      end
      if (got >= n) ok = 1'b1;
    end
    repeat (GAP + 3) tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cfg_mode_sel = 3'd3;
    repeat (2) tick();
    total++;
    if ({data_do_en, frame_do_start, frame_do_done, err_do_len, busy_do} !== 5'b0) begin
      bad++; $display("[TB] FAIL reset_flags got=%b want=00000",
        {data_do_en, frame_do_start, frame_do_done, err_do_len, busy_do});
    end
    total++;
    if ({data_do_re, data_do_im} !== '0) begin
      bad++; $display("[TB] FAIL reset_data got=%h want=0", {data_do_re, data_do_im});
    end
    total++;
    if (mode_do_sel !== 3'd5) begin
      bad++; $display("[TB] FAIL reset_mode got=%0d want=5", mode_do_sel);
    end
    reset = 1'b0;
    tick();
    total++;
    if ({s_ready, data_do_en, busy_do} !== 3'b100) begin
      bad++; $display("[TB] FAIL after_reset got=%b want=100", {s_ready, data_do_en, busy_do});
    end
  endtask

  task automatic test_two_frames();
    int base, k, got, i_done, i_start2, errs;
    bit ok, saw_not_ready;
    rec_t r;
    logic [37:0] obs, expv;
    do_reset();
    cfg_mode_sel = 3'd0;
    base = rec_q.size();
    make_stim(64, 31, 63);
    drive(1'b0, -1, 3'd0);
    wait_enabled(base, 64, 400, ok, got);
    total++;
    if (!ok) begin bad++; $display("[TB] FAIL two_frames_timeout got=%0d want=64", got); end
    k = 0; i_done = -1; i_start2 = -1; errs = 0; saw_not_ready = 1'b0;
    for (int i = base; i < rec_q.size(); i++) begin
      r = rec_q[i];
      if (!r.ready) saw_not_ready = 1'b1;
      if (r.en) begin
        if (k < pushed_q.size()) begin
          expv = model_next(pushed_q[k], r.cfg);
          obs  = {r.start, r.done, r.err, r.mode, r.re, r.im};
          total++;
          if (obs !== expv) begin
            bad++; $display("[TB] FAIL two_frames_s%0d got=%h want=%h", k, obs, expv);
          end
          if (k == 0) begin
            total++;
            if (r.cyc !== pushed_q[0].cyc + 1) begin
              bad++; $display("[TB] FAIL latency got=%0d want=%0d", r.cyc, pushed_q[0].cyc + 1);
            end
          end
        end
        if (k == 31) i_done = i;
        if (k == 32) i_start2 = i;
        if (r.err) errs++;
        k++;
      end else begin
        total++;
        if ({r.start, r.done, r.err, r.re, r.im} !== '0) begin
          bad++; $display("[TB] FAIL two_frames_hole got=%h want=0", {r.start, r.done, r.err, r.re, r.im});
        end
      end
    end
    total++;
    if (k != 64) begin bad++; $display("[TB] FAIL two_frames_count got=%0d want=64", k); end
    total++;
    if (i_start2 - i_done != GAP + 1) begin
      bad++; $display("[TB] FAIL gap_len got=%0d want=%0d", i_start2 - i_done - 1, GAP);
    end
    if (i_done >= 0 && i_done + GAP < rec_q.size()) begin
      total++;
      if ({rec_q[i_done+1].busy, rec_q[i_done+2].busy, rec_q[i_done+3].busy,
           rec_q[i_done+4].busy} !== 4'b1110) begin
        bad++; $display("[TB] FAIL gap_busy got=%b want=1110", {rec_q[i_done+1].busy,
          rec_q[i_done+2].busy, rec_q[i_done+3].busy, rec_q[i_done+4].busy});
      end
      total++;
      if (rec_q[i_done+4].mode !== 3'd0) begin
        bad++; $display("[TB] FAIL gap_mode got=%0d want=0", rec_q[i_done+4].mode);
      end
    end
    total++;
    if (saw_not_ready !== 1'b1) begin bad++; $display("[TB] FAIL ready_drop got=0 want=1"); end
    total++;
    if (errs != 0) begin bad++; $display("[TB] FAIL two_frames_err got=%0d want=0", errs); end
  endtask

  task automatic test_mode_switch();
    int base, k, got;
    bit ok;
    rec_t r;
    logic [37:0] obs, expv;
    do_reset();
    cfg_mode_sel = 3'd5;
    base = rec_q.size();
    make_stim(1056, 1023, 1055);
    drive(1'b0, 100, 3'd0);
    wait_enabled(base, 1056, 3000, ok, got);
    total++;
    if (!ok) begin bad++; $display("[TB] FAIL switch_timeout got=%0d want=1056", got); end
    k = 0;
    for (int i = base; i < rec_q.size(); i++) begin
      r = rec_q[i];
      if (r.en) begin
        if (k < pushed_q.size()) begin
          expv = model_next(pushed_q[k], r.cfg);
          obs  = {r.start, r.done, r.err, r.mode, r.re, r.im};
          total++;
          if (obs !== expv) begin
            bad++; $display("[TB] FAIL switch_s%0d got=%h want=%h", k, obs, expv);
          end
        end
        if (k == 1024) begin
          total++;
          if (r.mode !== 3'd0) begin bad++; $display("[TB] FAIL switch_next_mode got=%0d want=0", r.mode); end
        end
        k++;
      end
    end
    total++;
    if (k != 1056) begin bad++; $display("[TB] FAIL switch_count got=%0d want=1056", k); end
  endtask

  task automatic test_toggle();
    int base, k, got, holes, first, last_i;
    bit ok;
    rec_t r;
    logic [37:0] obs, expv;
    do_reset();
    cfg_mode_sel = 3'd1;
    base = rec_q.size();
    make_stim(64, 63, -1);
    drive(1'b1, -1, 3'd1);
    wait_enabled(base, 64, 400, ok, got);
    total++;
    if (!ok) begin bad++; $display("[TB] FAIL toggle_timeout got=%0d want=64", got); end
    k = 0; first = -1; last_i = -1;
    for (int i = base; i < rec_q.size(); i++) begin
      r = rec_q[i];
      if (r.en) begin
        if (first < 0) first = i;
        last_i = i;
        if (k < pushed_q.size()) begin
          expv = model_next(pushed_q[k], r.cfg);
          obs  = {r.start, r.done, r.err, r.mode, r.re, r.im};
          total++;
          if (obs !== expv) begin
            bad++; $display("[TB] FAIL toggle_s%0d got=%h want=%h", k, obs, expv);
          end
        end
        k++;
      end
    end
    holes = (last_i - first + 1) - k;
    total++;
    if (k != 64 || holes != 63) begin
      bad++; $display("[TB] FAIL toggle_shape got=%0d/%0d want=64/63", k, holes);
    end
  endtask

  task automatic test_len_error();
    int base, k, got, errs;
    bit ok;
    rec_t r;
    logic [37:0] obs, expv;
    do_reset();
    cfg_mode_sel = 3'd0;
    base = rec_q.size();
    make_stim(32, 20, -1);
    drive(1'b0, -1, 3'd0);
    wait_enabled(base, 32, 400, ok, got);
    total++;
    if (!ok) begin bad++; $display("[TB] FAIL lenerr_timeout got=%0d want=32", got); end
    k = 0; errs = 0;
    for (int i = base; i < rec_q.size(); i++) begin
      r = rec_q[i];
      if (r.en) begin
        if (k < pushed_q.size()) begin
          expv = model_next(pushed_q[k], r.cfg);
          obs  = {r.start, r.done, r.err, r.mode, r.re, r.im};
          total++;
          if (obs !== expv) begin
            bad++; $display("[TB] FAIL lenerr_s%0d got=%h want=%h", k, obs, expv);
          end
        end
        if (r.err) errs++;
        k++;
      end
    end
    total++;
    if (errs != 2 || k != 32) begin
      bad++; $display("[TB] FAIL lenerr_summary got=%0d/%0d want=2/32", errs, k);
    end
  endtask

  task automatic test_reset_mid();
    int base, k, got, dones, ens;
    bit ok;
    rec_t r;
    logic [37:0] obs, expv;
    do_reset();
    cfg_mode_sel = 3'd2;
    base = rec_q.size();
    make_stim(11, -1, -1);
    drive(1'b0, -1, 3'd2);
    reset = 1'b1;
    tick();
    total++;
    if ({data_do_en, frame_do_start, frame_do_done, err_do_len, busy_do, mode_do_sel, s_ready}
        !== {5'b0, 3'd5, 1'b1}) begin
      bad++; $display("[TB] FAIL midreset_state got=%b want=000001011",
        {data_do_en, frame_do_start, frame_do_done, err_do_len, busy_do, mode_do_sel, s_ready});
    end
    reset = 1'b0;
    repeat (4) tick();
    dones = 0; ens = 0;
    for (int i = base; i < rec_q.size(); i++) begin
      if (rec_q[i].done) dones++;
      if (i >= rec_q.size() - 4 && rec_q[i].en) ens++;
    end
    total++;
    if (dones != 0 || ens != 0) begin
      bad++; $display("[TB] FAIL midreset_flush got=%0d/%0d want=0/0", dones, ens);
    end
    pushed_q.delete();
    m_pos = 0;
    base = rec_q.size();
    make_stim(128, 127, -1);
    drive(1'b0, -1, 3'd2);
    wait_enabled(base, 128, 600, ok, got);
    total++;
    if (!ok) begin bad++; $display("[TB] FAIL midreset_timeout got=%0d want=128", got); end
    k = 0;
    for (int i = base; i < rec_q.size(); i++) begin
      r = rec_q[i];
      if (r.en) begin
        if (k < pushed_q.size()) begin
          expv = model_next(pushed_q[k], r.cfg);
          obs  = {r.start, r.done, r.err, r.mode, r.re, r.im};
          total++;
          if (obs !== expv) begin
            bad++; $display("[TB] FAIL midreset_s%0d got=%h want=%h", k, obs, expv);
          end
        end
        k++;
      end
    end
    total++;
    if (k != 128) begin bad++; $display("[TB] FAIL midreset_count got=%0d want=128", k); end
  endtask

  task automatic test_mode7();
    int base, k, got, dones;
    bit ok;
    rec_t r;
    logic [37:0] obs, expv;
    do_reset();
    cfg_mode_sel = 3'd7;
    base = rec_q.size();
    make_stim(1024, 1023, -1);
    drive(1'b0, -1, 3'd7);
    wait_enabled(base, 1024, 2000, ok, got);
    total++;
    if (!ok) begin bad++; $display("[TB] FAIL mode7_timeout got=%0d want=1024", got); end
    k = 0; dones = 0;
    for (int i = base; i < rec_q.size(); i++) begin
      r = rec_q[i];
      if (r.en) begin
        if (k < pushed_q.size()) begin
          expv = model_next(pushed_q[k], r.cfg);
          obs  = {r.start, r.done, r.err, r.mode, r.re, r.im};
          total++;
          if (obs !== expv) begin
            bad++; $display("[TB] FAIL mode7_s%0d got=%h want=%h", k, obs, expv);
          end
        end
        if (r.done) dones++;
        k++;
      end
    end
    total++;
    if (k != 1024 || dones != 1) begin
      bad++; $display("[TB] FAIL mode7_len got=%0d/%0d want=1024/1", k, dones);
    end
  endtask

  initial begin
    test_reset();
    test_two_frames();
    test_mode_switch();
    test_toggle();
    test_len_error();
    test_reset_mid();
    test_mode7();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog got=running want=finished");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
